// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock, one block in flight.
// Round keys come from an upstream key-schedule block and must be held stable while busy.
module aes128_encrypt_iter #(
  parameter int unsigned NR = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    plaintext,
  input  logic [1407:0]   round_keys,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    ciphertext,
  output logic            busy
);

  if (NR != 10) begin : gen_nr_check
    $error("aes128_encrypt_iter supports only NR = 10");
  end

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SboxTbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk [11];
  logic [127:0] rk_cur;
  logic [127:0] sr_out;
  logic [127:0] mc_out;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTbl[8 * (255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k of the state lives at [127-8k -: 8]; k = row + 4*column.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[8 * (15 - (r + 4 * c)) +: 8] = sbox(s[8 * (15 - (r + 4 * ((c + r) % 4))) +: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8 * (15 - 4 * c) +: 8];
      a1 = s[8 * (14 - 4 * c) +: 8];
      a2 = s[8 * (13 - 4 * c) +: 8];
      a3 = s[8 * (12 - 4 * c) +: 8];
      o[8 * (15 - 4 * c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[8 * (14 - 4 * c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[8 * (13 - 4 * c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[8 * (12 - 4 * c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  for (genvar r = 0; r < 11; r++) begin : gen_rk
    assign rk[r] = round_keys[(10 - r) * 128 +: 128];
  end

  assign rk_cur = (rnd_q <= 4'd10) ? rk[rnd_q] : '0;
  assign sr_out = sub_shift(st_q);
  assign mc_out = mix_columns(sr_out);

  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    st_d       = st_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    ciphertext = '0;
    busy       = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_d    = plaintext ^ rk[0];
          rnd_d   = 4'd1;
          state_d = StRound;
        end
      end
      StRound: begin
        busy = 1'b1;
        if (rnd_q == 4'(NR)) begin
          st_d    = sr_out ^ rk_cur;
          state_d = StDone;
        end else begin
          st_d  = mc_out ^ rk_cur;
          rnd_d = rnd_q + 4'd1;
        end
      end
      StDone: begin
        busy       = 1'b1;
        out_valid  = 1'b1;
        ciphertext = st_q;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rnd_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
    end
  end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Directed and randomised bench for aes128_encrypt_iter against FIPS-197 vectors
// and an independently derived software AES model.
module tb_aes128_encrypt_iter;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [127:0]  plaintext = '0;
  logic [1407:0] round_keys = '0;
  logic          in_ready;
  logic          out_valid;
  logic          busy;
  logic [127:0]  ciphertext;

  int n_cmp = 0;
  int n_err = 0;
  int sbox_t [256];

  typedef logic [0:15][7:0] st_t;
  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes128_encrypt_iter #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .round_keys (round_keys),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] b);
    return sbox_t[b][7:0];
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] rks;
    rc = 8'h01;
    rks = '0;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]) ^ rc, sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rks[1407 - 128 * r -: 128] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    return rks;
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
    logic [1407:0] rks;
    st_t s, b, t, m;
    rks = expand(key);
    s = pt ^ rks[1407 -: 128];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) b[k] = sb(s[k]);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r + 4 * c] = b[r + 4 * ((c + r) % 4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            m[4 * c + r] = gmul(8'h02, t[4 * c + r]) ^ gmul(8'h03, t[4 * c + (r + 1) % 4])
                         ^ t[4 * c + (r + 2) % 4] ^ t[4 * c + (r + 3) % 4];
      end else begin
        m = t;
      end
      s = m ^ rks[1407 - 128 * rnd -: 128];
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Waits (from a negedge) for in_ready with in_valid already driven, then crosses the accept edge.
  task automatic wait_accept(input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_accept"}, 256'(n < 100), 256'(1));
    @(negedge clk);
  endtask

  task automatic wait_valid(input string nm);
    int lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, 256'(lat), 256'(10));
  endtask

  task automatic do_block(input logic [127:0] key, input logic [127:0] pt,
                          input logic [127:0] exp, input bit rnd_ready, input string nm);
    int n;
    bit hs;
    round_keys = expand(key);
    plaintext  = pt;
    in_valid   = 1'b1;
    wait_accept(nm);
    in_valid  = 1'b0;
    plaintext = rand128();
    wait_valid(nm);
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 64) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      check({nm, "_ct"}, {127'd0, out_valid, ciphertext}, {127'd0, 1'b1, exp});
      hs = out_valid && out_ready;
      @(negedge clk);
      n++;
    end
    check({nm, "_handshake"}, 256'(hs), 256'(1));
    check({nm, "_no_dup"}, {254'd0, out_valid, in_ready}, {254'd0, 1'b0, 1'b1});
    out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] inv, k, p, pt2;

    for (int x = 0; x < 256; x++) begin
      inv = '0;
      if (x != 0)
        for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 128'(y);
      sbox_t[x] = int'(inv[7:0] ^ rotl8(inv[7:0], 1) ^ rotl8(inv[7:0], 2)
                     ^ rotl8(inv[7:0], 3) ^ rotl8(inv[7:0], 4) ^ 8'h63);
    end

    vecs[0] = '{key: KeyB, pt: PtB, ct: CtB};
    vecs[1] = '{key: KeyC, pt: PtC, ct: CtC};
    vecs[2] = '{key: '0, pt: '0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    // Reset state
    #12;
    check("reset_active", {125'd0, out_valid, busy, 1'b0, ciphertext}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release", {124'd0, in_ready, out_valid, busy, 1'b0, ciphertext},
          {124'd0, 1'b1, 131'd0});

    foreach (vecs[i]) do_block(vecs[i].key, vecs[i].pt, vecs[i].ct, 1'b0,
                               $sformatf("vec%0d", i));

    // Backpressure: DONE held for 20 cycles with out_ready low
    round_keys = expand(KeyC);
    plaintext  = PtC;
    in_valid   = 1'b1;
    wait_accept("bp");
    in_valid = 1'b0;
    wait_valid("bp");
    for (int i = 0; i < 20; i++) begin
      check($sformatf("bp_hold%0d", i), {126'd0, out_valid, in_ready, ciphertext},
            {126'd0, 1'b1, 1'b0, CtC});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release", {254'd0, in_ready, out_valid}, {254'd0, 1'b1, 1'b0});

    // in_valid held high with a new plaintext while busy
    pt2 = 128'h0123456789abcdeffedcba9876543210;
    round_keys = expand(KeyB);
    plaintext  = PtB;
    in_valid   = 1'b1;
    wait_accept("hold1");
    plaintext = pt2;
    wait_valid("hold1");
    check("hold1_ct", {128'd0, ciphertext}, {128'd0, CtB});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold_idle", {254'd0, in_ready, busy}, {254'd0, 1'b1, 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid("hold2");
    check("hold2_ct", {128'd0, ciphertext}, {128'd0, aes_model(KeyB, pt2)});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset mid-operation at round 5
    round_keys = expand(KeyB);
    plaintext  = PtB;
    in_valid   = 1'b1;
    wait_accept("rst");
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_mid", {126'd0, out_valid, busy, ciphertext}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check($sformatf("rst_abandon%0d", i), {254'd0, out_valid, busy}, 256'd0);
    end
    do_block(KeyB, PtB, CtB, 1'b0, "rst_after");

    // Random keys and plaintexts with random backpressure
    for (int i = 0; i < 1000; i++) begin
      k = rand128();
      p = rand128();
      do_block(k, p, aes_model(k, p), 1'b1, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
